// File: rtl/prio_enc_serializer_pkg.sv
// Shared types and helpers for the priority-encoder serializer.
package prio_enc_pkg;

  // Widest vector the one-hot helper can judge; wider callers are truncated.
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index width for a WIDTH-bit vector; never narrower than one bit.
  function automatic int num_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // True when exactly one bit is set (clearing the lowest set bit leaves zero).
  function automatic logic is_one_hot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_enc_serializer_comb.sv
// Purely combinational priority encoder of arbitrary width.
module prio_enc_comb #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NUM_W    = prio_enc_pkg::num_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [NUM_W-1:0] idx,
  output logic             found
);

  // Scan toward the winning end so the last hit is the priority bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx   = NUM_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = NUM_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_enc_serializer.sv
// Accepts a request vector and emits the index of each set bit, one per
// output handshake, in priority order.
module prio_enc_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NUM_W    = prio_enc_pkg::num_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] num,
  output logic             out_last,
  output logic             busy
);
  import prio_enc_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [NUM_W-1:0] idx;
  logic             found;
  logic             last;

  prio_enc_comb #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_enc (
    .vec  (pend),
    .idx  (idx),
    .found(found)
  );

  // num/out_last depend on pend only, so they stay stable under backpressure.
  assign last     = is_one_hot(MAX_W'(pend));
  assign num      = (state == SCAN && found) ? idx : '0;
  assign out_last = (state == SCAN) && last;

  // Control FSM: load on accept, retire one index per fire, leave on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // A zero vector is consumed but produces nothing.
          if (in_valid && in_ready && vector != '0) begin
            pend      <= vector;
            state     <= SCAN;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        SCAN: begin
          if (out_valid && out_ready) begin
            if (last) begin
              pend      <= '0;
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              pend <= pend & ~(WIDTH'(1) << idx);
            end
          end
        end
        default: begin
          state     <= IDLE;
          pend      <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_enc_serializer.sv
// Scoreboard bench: three instances (8/MSB, 8/LSB, 12/MSB) share one clock;
// expected indices are queued by the stimulus and checked by a monitor.
module tb_prio_enc_serializer;

  logic        clk = 1'b0;
  logic [2:0]  rst, in_valid, out_ready;
  logic [11:0] vec [3];
  logic [2:0]  in_ready, ov, ol, busy;
  logic [2:0]  num0, num1;
  logic [3:0]  num2;
  logic [3:0]  nm [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int d;
    int num;
    int last;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  assign nm[0] = {1'b0, num0};
  assign nm[1] = {1'b0, num1};
  assign nm[2] = num2;

  prio_enc_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .vector(vec[0][7:0]), .out_valid(ov[0]), .out_ready(out_ready[0]),
    .num(num0), .out_last(ol[0]), .busy(busy[0]));

  prio_enc_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .vector(vec[1][7:0]), .out_valid(ov[1]), .out_ready(out_ready[1]),
    .num(num1), .out_last(ol[1]), .busy(busy[1]));

  prio_enc_serializer #(.WIDTH(12), .MSB_FIRST(1'b1)) u_w12 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .vector(vec[2]), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .num(num2), .out_last(ol[2]), .busy(busy[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every fire (not under reset) must match the head of the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && out_ready[d] && !rst[d]) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output dut=%0d actual num=%0d required none", d, nm[d]);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("sb_dut%0d", d), d, e.d);
          chk($sformatf("sb_num%0d", d), int'(nm[d]), e.num);
          chk($sformatf("sb_last%0d", d), int'(ol[d]), e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int d, input int n, input int last);
    exp_t e;
    e.d = d; e.num = n; e.last = last;
    q.push_back(e);
  endtask

  // Present a vector for one edge; check ready at accept and latency after.
  task automatic accept(input int d, input logic [11:0] v);
    vec[d]      = v;
    in_valid[d] = 1'b1;
    chk("accept_ready", int'(in_ready[d]), 1);
    tick();
    in_valid[d] = 1'b0;
    chk("accept_latency", int'(ov[d]), (v != 12'h0) ? 1 : 0);
  endtask

  // Expect n back-to-back SCAN cycles, then the bubble with in_ready high.
  task automatic drain(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      chk("scan_valid", int'(ov[d]), 1);
      chk("scan_ready_low", int'(in_ready[d]), 0);
      tick();
    end
    chk("done_valid", int'(ov[d]), 0);
    chk("bubble_ready", int'(in_ready[d]), 1);
  endtask

  task automatic idle_checks(input string tag, input int d);
    chk({tag, "_valid"}, int'(ov[d]), 0);
    chk({tag, "_num"}, int'(nm[d]), 0);
    chk({tag, "_last"}, int'(ol[d]), 0);
    chk({tag, "_ready"}, int'(in_ready[d]), 1);
    chk({tag, "_busy"}, int'(busy[d]), 0);
  endtask

  initial begin
    // 1: reset held with a full vector offered; nothing may be accepted.
    rst       = 3'b111;
    in_valid  = 3'b111;
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) vec[d] = 12'hFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int d = 0; d < 3; d++) idle_checks("reset", d);
    end
    rst      = 3'b000;
    in_valid = 3'b000;
    tick();
    for (int d = 0; d < 3; d++) idle_checks("post_reset", d);

    // 2: MSB-first, 1010_0101 -> 7,5,2,0.
    expect_out(0, 7, 0); expect_out(0, 5, 0); expect_out(0, 2, 0); expect_out(0, 0, 1);
    accept(0, 12'h0A5);
    drain(0, 4);

    // 3: LSB-first, same vector -> 0,2,5,7; then single bit 4.
    expect_out(1, 0, 0); expect_out(1, 2, 0); expect_out(1, 5, 0); expect_out(1, 7, 1);
    accept(1, 12'h0A5);
    drain(1, 4);
    expect_out(1, 4, 1);
    accept(1, 12'h010);
    drain(1, 1);

    // 4: backpressure on 8'h81, with a competing vector offered during SCAN.
    out_ready[0] = 1'b0;
    accept(0, 12'h081);
    vec[0]      = 12'h03C;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", int'(ov[0]), 1);
      chk("hold_num", int'(nm[0]), 7);
      chk("hold_last", int'(ol[0]), 0);
      chk("hold_ready", int'(in_ready[0]), 0);
      tick();
    end
    expect_out(0, 7, 0); expect_out(0, 0, 1);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    drain(0, 2);

    // 5: zero vector is consumed silently; then 8'h02 -> 1.
    accept(0, 12'h000);
    chk("zero_busy", int'(busy[0]), 0);
    chk("zero_ready", int'(in_ready[0]), 1);
    tick();
    chk("zero_still_idle", int'(ov[0]), 0);
    expect_out(0, 1, 1);
    accept(0, 12'h002);
    drain(0, 1);

    // 6: 12-bit, reset after index 11 fires drops index 0.
    expect_out(2, 11, 0);
    accept(2, 12'h801);
    tick();
    chk("w12_pending0_num", int'(nm[2]), 0);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    idle_checks("w12_after_rst", 2);
    expect_out(2, 10, 1);
    accept(2, 12'h400);
    drain(2, 1);

    tick();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
